// File: rtl/s_machine_mem_arbiter_pkg.sv
// s_machine_pkg: shared widths and enums for the S-Machine memory arbiter.
// Imported by the interface, the pick sub-module and the top.
package s_machine_pkg;

  localparam int ADDR_W   = 8;
  localparam int DATA_W   = 16;
  localparam int LAT_W    = 2;
  localparam int STARVE_W = 4;

  typedef enum logic {
    IDLE,
    WAIT
  } arb_state_t;

  typedef enum logic {
    OWN_FETCH,
    OWN_DATA
  } arb_owner_t;

endpackage

// File: rtl/s_machine_mem_arbiter_if.sv
// s_machine_mem_arbiter_if: fetch port, data port and memory bus signals.
// slave = arbiter side, master = requesters plus memory array side.
interface s_machine_mem_arbiter_if
  import s_machine_pkg::*;
();

  logic              f_req;
  logic [ADDR_W-1:0] f_addr;
  logic              f_gnt;
  logic              f_valid;
  logic [DATA_W-1:0] f_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_valid;
  logic [DATA_W-1:0] d_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  f_req, f_addr,
    input  d_req, d_we, d_addr, d_wdata,
    input  mem_rdata,
    output f_gnt, f_valid, f_rdata,
    output d_gnt, d_valid, d_rdata,
    output mem_addr, mem_we, mem_wdata
  );

  modport master (
    output f_req, f_addr,
    output d_req, d_we, d_addr, d_wdata,
    output mem_rdata,
    input  f_gnt, f_valid, f_rdata,
    input  d_gnt, d_valid, d_rdata,
    input  mem_addr, mem_we, mem_wdata
  );

endinterface

// File: rtl/s_machine_arb_pick.sv
// s_machine_arb_pick: combinational winner select between fetch and data.
// Ports: d_req, f_req, starve_cnt in; owner, any_grant out.
module s_machine_arb_pick
  import s_machine_pkg::*;
#(
  parameter int STARVE_LIMIT = 3
) (
  input  logic                d_req,
  input  logic                f_req,
  input  logic [STARVE_W-1:0] starve_cnt,
  output arb_owner_t          owner,
  output logic                any_grant
);

  logic starved;

  assign starved = d_req && f_req &&
    (starve_cnt == STARVE_W'(STARVE_LIMIT));

  always_comb begin
    owner     = OWN_FETCH;
    any_grant = d_req || f_req;
    if (starved)
      owner = OWN_FETCH;
    else if (d_req)
      owner = OWN_DATA;
    else
      owner = OWN_FETCH;
  end

endmodule

// File: rtl/s_machine_mem_arbiter.sv
// s_machine_mem_arbiter: shares one 256x16 sync memory between fetch and data.
// Ports: clk, reset (sync, active-high), bus (slave modport).
// Build option S_MACHINE_ARB_STATS_EN adds f_gnt_count, d_gnt_count,
// starve_event_count outputs.
module s_machine_mem_arbiter
  import s_machine_pkg::*;
#(
  parameter int MEM_LAT      = 1,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  s_machine_mem_arbiter_if.slave bus
`ifdef S_MACHINE_ARB_STATS_EN
  ,
  output logic [15:0]           f_gnt_count,
  output logic [15:0]           d_gnt_count,
  output logic [7:0]            starve_event_count
`endif
);

  arb_state_t          state_q, state_d;
  logic [LAT_W-1:0]    lat_q, lat_d;
  logic                pend_q, pend_d;
  arb_owner_t          own_q, own_d;
  logic                wr_q, wr_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic [DATA_W-1:0]   f_rdata_q, d_rdata_q;

  arb_owner_t owner;
  logic       any_grant;
  logic       slot, resp, grant;
  logic       f_win, d_win;

  s_machine_arb_pick #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_pick (
    .d_req     (bus.d_req),
    .f_req     (bus.f_req),
    .starve_cnt(starve_q),
    .owner     (owner),
    .any_grant (any_grant)
  );

  // A grant slot opens in IDLE or in the last WAIT cycle, which is
  // also the response cycle of the access in flight.
  assign slot  = (state_q == IDLE) || (lat_q == '0);
  assign resp  = pend_q && (lat_q == '0) && !reset;
  assign grant = slot && any_grant && !reset;
  assign f_win = grant && (owner == OWN_FETCH);
  assign d_win = grant && (owner == OWN_DATA);

  always_comb begin
    bus.f_gnt     = f_win;
    bus.d_gnt     = d_win;
    bus.mem_addr  = '0;
    bus.mem_we    = d_win && bus.d_we;
    bus.mem_wdata = '0;
    if (f_win)
      bus.mem_addr = bus.f_addr;
    else if (d_win)
      bus.mem_addr = bus.d_addr;
    if (d_win && bus.d_we)
      bus.mem_wdata = bus.d_wdata;

    bus.f_valid = resp && (own_q == OWN_FETCH);
    bus.d_valid = resp && (own_q == OWN_DATA);
    // Read data passes straight through on its response cycle and is
    // held in the per-port register afterwards.
    bus.f_rdata = bus.f_valid ? bus.mem_rdata : f_rdata_q;
    bus.d_rdata = (bus.d_valid && !wr_q) ? bus.mem_rdata : d_rdata_q;
  end

  always_comb begin
    state_d  = state_q;
    lat_d    = lat_q;
    pend_d   = pend_q;
    own_d    = own_q;
    wr_d     = wr_q;
    starve_d = starve_q;

    if (grant) begin
      pend_d  = 1'b1;
      own_d   = owner;
      wr_d    = d_win && bus.d_we;
      lat_d   = LAT_W'(MEM_LAT - 1);
      state_d = (MEM_LAT > 1) ? WAIT : IDLE;
    end else if (state_q == WAIT) begin
      if (lat_q == '0) begin
        state_d = IDLE;
        pend_d  = 1'b0;
      end else begin
        lat_d = lat_q - 1'b1;
      end
    end else begin
      pend_d = 1'b0;
    end

    if (!bus.f_req || f_win)
      starve_d = '0;
    else if (d_win && starve_q != STARVE_W'(STARVE_LIMIT))
      starve_d = starve_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      lat_q     <= '0;
      pend_q    <= 1'b0;
      own_q     <= OWN_FETCH;
      wr_q      <= 1'b0;
      starve_q  <= '0;
      f_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q  <= state_d;
      lat_q    <= lat_d;
      pend_q   <= pend_d;
      own_q    <= own_d;
      wr_q     <= wr_d;
      starve_q <= starve_d;
      if (bus.f_valid)
        f_rdata_q <= bus.mem_rdata;
      if (bus.d_valid && !wr_q)
        d_rdata_q <= bus.mem_rdata;
    end
  end

`ifdef S_MACHINE_ARB_STATS_EN
  logic forced;

  assign forced = grant && bus.f_req && bus.d_req &&
    (starve_q == STARVE_W'(STARVE_LIMIT));

  always_ff @(posedge clk) begin
    if (reset) begin
      f_gnt_count        <= '0;
      d_gnt_count        <= '0;
      starve_event_count <= '0;
    end else begin
      if (f_win && f_gnt_count != '1)
        f_gnt_count <= f_gnt_count + 1'b1;
      if (d_win && d_gnt_count != '1)
        d_gnt_count <= d_gnt_count + 1'b1;
      if (forced && starve_event_count != '1)
        starve_event_count <= starve_event_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_s_machine_mem_arbiter.sv
// tb_s_machine_mem_arbiter: directed checks on three arbiters
// (MEM_LAT = 1, 3, 2), each with its own memory model.
module tb_s_machine_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic load;

  logic [2:0]  f_req, d_req, d_we;
  logic [7:0]  f_addr [3];
  logic [7:0]  d_addr [3];
  logic [15:0] d_wdata [3];

  logic [2:0]  f_gnt, f_valid, d_gnt, d_valid, mem_we;
  logic [15:0] f_rdata [3];
  logic [15:0] d_rdata [3];
  logic [15:0] mem_wdata [3];
  logic [7:0]  mem_addr [3];

`ifdef S_MACHINE_ARB_STATS_EN
  logic [15:0] fgc [3];
  logic [15:0] dgc [3];
  logic [7:0]  sec [3];
`endif

  int total = 0;
  int bad = 0;

  function automatic logic [15:0] pat(input logic [7:0] a);
    return 16'h0401 + {a, a};
  endfunction

  for (genvar g = 0; g < 3; g++) begin : u
    localparam int L = (g == 0) ? 1 : (g == 1) ? 3 : 2;

    s_machine_mem_arbiter_if bus ();

    logic [15:0] mem [256];
    logic [15:0] pipe [4];

    assign bus.f_req   = f_req[g];
    assign bus.f_addr  = f_addr[g];
    assign bus.d_req   = d_req[g];
    assign bus.d_we    = d_we[g];
    assign bus.d_addr  = d_addr[g];
    assign bus.d_wdata = d_wdata[g];
    assign bus.mem_rdata = pipe[L-1];

    assign f_gnt[g]     = bus.f_gnt;
    assign f_valid[g]   = bus.f_valid;
    assign f_rdata[g]   = bus.f_rdata;
    assign d_gnt[g]     = bus.d_gnt;
    assign d_valid[g]   = bus.d_valid;
    assign d_rdata[g]   = bus.d_rdata;
    assign mem_addr[g]  = bus.mem_addr;
    assign mem_we[g]    = bus.mem_we;
    assign mem_wdata[g] = bus.mem_wdata;

    always @(posedge clk) begin
      if (load) begin
        for (int i = 0; i < 256; i++)
          mem[i] <= pat(8'(i));
      end else if (bus.mem_we) begin
        mem[bus.mem_addr] <= bus.mem_wdata;
      end
      pipe[0] <= mem[bus.mem_addr];
      for (int i = 1; i < 4; i++)
        pipe[i] <= pipe[i-1];
    end

    s_machine_mem_arbiter #(
      .MEM_LAT(L),
      .STARVE_LIMIT(3)
    ) dut (
      .clk  (clk),
      .reset(rst),
      .bus  (bus.slave)
`ifdef S_MACHINE_ARB_STATS_EN
      ,
      .f_gnt_count       (fgc[g]),
      .d_gnt_count       (dgc[g]),
      .starve_event_count(sec[g])
`endif
    );
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst   = 1'b1;
    load  = 1'b1;
    f_req = '0;
    d_req = '0;
    d_we  = '0;
    for (int i = 0; i < 3; i++) begin
      f_addr[i]  = '0;
      d_addr[i]  = '0;
      d_wdata[i] = '0;
    end

    // reset state
    tick();
    tick();
    @(negedge clk);
    chk("rst_gnt", {f_gnt[0], d_gnt[0]}, 0);
    chk("rst_valid", {f_valid[0], d_valid[0]}, 0);
    chk("rst_mem", {mem_we[0], mem_addr[0], mem_wdata[0]}, 0);
    chk("rst_rdata", {f_rdata[0], d_rdata[0]}, 0);
`ifdef S_MACHINE_ARB_STATS_EN
    chk("rst_stats", {fgc[0], dgc[0]}, 0);
`endif

    tick();
    rst  = 1'b0;
    load = 1'b0;
    @(negedge clk);
    chk("idle_gnt", {f_gnt[0], d_gnt[0], mem_we[0]}, 0);

    // single fetch, MEM_LAT=1
    tick();
    f_req[0]  = 1'b1;
    f_addr[0] = 8'h00;
    @(negedge clk);
    chk("t1_fgnt", f_gnt[0], 1);
    chk("t1_maddr", mem_addr[0], 8'h00);
    chk("t1_fvalid_early", f_valid[0], 0);
    tick();
    f_req[0] = 1'b0;
    @(negedge clk);
    chk("t1_fvalid", f_valid[0], 1);
    chk("t1_frdata", f_rdata[0], 16'h0401);
    chk("t1_fgnt_off", f_gnt[0], 0);
    tick();
    @(negedge clk);
    chk("t1_fvalid_off", f_valid[0], 0);
    chk("t1_frdata_hold", f_rdata[0], 16'h0401);

    // write then read same address
    tick();
    d_req[0]   = 1'b1;
    d_we[0]    = 1'b1;
    d_addr[0]  = 8'h10;
    d_wdata[0] = 16'hBEEF;
    @(negedge clk);
    chk("t2_wgnt", d_gnt[0], 1);
    chk("t2_we", mem_we[0], 1);
    chk("t2_waddr", mem_addr[0], 8'h10);
    chk("t2_wdata", mem_wdata[0], 16'hBEEF);
    tick();
    d_we[0] = 1'b0;
    @(negedge clk);
    chk("t2_rgnt", d_gnt[0], 1);
    chk("t2_we_once", mem_we[0], 0);
    chk("t2_wack", d_valid[0], 1);
    chk("t2_wack_rdata", d_rdata[0], 16'h0000);
    tick();
    d_req[0] = 1'b0;
    @(negedge clk);
    chk("t2_rvalid", d_valid[0], 1);
    chk("t2_rdata", d_rdata[0], 16'hBEEF);
    chk("t2_we_idle", mem_we[0], 0);
    tick();
    @(negedge clk);
    chk("t2_rvalid_off", d_valid[0], 0);
    chk("t2_rdata_hold", d_rdata[0], 16'hBEEF);

    // starvation: D,D,D,F,D,D,D,F
    tick();
    f_req[0]  = 1'b1;
    f_addr[0] = 8'h20;
    d_req[0]  = 1'b1;
    d_we[0]   = 1'b0;
    d_addr[0] = 8'h30;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk($sformatf("t3_fgnt%0d", k), f_gnt[0], (k % 4 == 3));
      chk($sformatf("t3_dgnt%0d", k), d_gnt[0], (k % 4 != 3));
      if (k < 7)
        tick();
    end
    tick();
    f_req[0] = 1'b0;
    d_req[0] = 1'b0;
    @(negedge clk);
    chk("t3_fvalid", f_valid[0], 1);
    chk("t3_frdata", f_rdata[0], 16'h2421);
    chk("t3_drdata", d_rdata[0], 16'h3431);
`ifdef S_MACHINE_ARB_STATS_EN
    chk("st_fgnt", fgc[0], 16'd3);
    chk("st_dgnt", dgc[0], 16'd8);
    chk("st_starve", sec[0], 8'd2);
`endif

    // MEM_LAT=3: second request waits for the response slot
    tick();
    d_req[1]  = 1'b1;
    d_addr[1] = 8'h40;
    @(negedge clk);
    chk("t4_dgnt", d_gnt[1], 1);
    tick();
    d_req[1]  = 1'b0;
    f_req[1]  = 1'b1;
    f_addr[1] = 8'h41;
    @(negedge clk);
    chk("t4_fgnt_t1", f_gnt[1], 0);
    chk("t4_dvalid_t1", d_valid[1], 0);
    tick();
    @(negedge clk);
    chk("t4_fgnt_t2", f_gnt[1], 0);
    chk("t4_dvalid_t2", d_valid[1], 0);
    tick();
    @(negedge clk);
    chk("t4_dvalid_t3", d_valid[1], 1);
    chk("t4_drdata", d_rdata[1], 16'h4441);
    chk("t4_fgnt_t3", f_gnt[1], 1);
    chk("t4_maddr", mem_addr[1], 8'h41);
    tick();
    f_req[1] = 1'b0;
    @(negedge clk);
    chk("t4_fvalid_t4", f_valid[1], 0);
    chk("t4_dvalid_t4", d_valid[1], 0);
    tick();
    @(negedge clk);
    chk("t4_fvalid_t5", f_valid[1], 0);
    tick();
    @(negedge clk);
    chk("t4_fvalid_t6", f_valid[1], 1);
    chk("t4_frdata", f_rdata[1], 16'h4542);

    // MEM_LAT=2: full read, then reset in flight
    tick();
    d_req[2]  = 1'b1;
    d_addr[2] = 8'h51;
    @(negedge clk);
    chk("t5_gnt_a", d_gnt[2], 1);
    tick();
    d_req[2] = 1'b0;
    @(negedge clk);
    chk("t5_valid_early", d_valid[2], 0);
    tick();
    @(negedge clk);
    chk("t5_valid_a", d_valid[2], 1);
    chk("t5_rdata_a", d_rdata[2], 16'h5552);
    tick();
    d_req[2]  = 1'b1;
    d_addr[2] = 8'h50;
    @(negedge clk);
    chk("t5_gnt_b", d_gnt[2], 1);
    tick();
    d_req[2] = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    chk("t5_rst_valid", d_valid[2], 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("t5_no_valid", d_valid[2], 0);
    chk("t5_rdata_clr", d_rdata[2], 16'h0000);
    chk("t5_gnt_clr", {f_gnt[2], d_gnt[2], f_valid[2]}, 0);
    chk("t5_mem_clr", {mem_we[2], mem_addr[2], mem_wdata[2]}, 0);
    chk("t5_frdata_clr", f_rdata[2], 16'h0000);
    chk("t5_a_rdata_clr", d_rdata[0], 16'h0000);
`ifdef S_MACHINE_ARB_STATS_EN
    chk("t5_stats_clr", {fgc[0], dgc[0], sec[0]}, 0);
`endif
    tick();
    @(negedge clk);
    chk("t5_no_valid_late", d_valid[2], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
